// File: rtl/serial_sub_unit_pkg.sv
// Shared definitions for the bit-serial arithmetic units.
package serial_arith_pkg;

    // Sequencer-visible state encodings
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Subtraction always starts with no incoming borrow
    localparam logic BORROW_IN = 1'b0;

endpackage

// File: rtl/serial_sub_unit_cell.sv
// One-bit combinational full subtractor: d = a - b - bin, with borrow out.
module full_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow generation for a single bit position
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_sub_unit.sv
// Bit-serial WIDTH-bit subtractor, diff = ain - bin (mod 2^WIDTH), LSB first,
// one bit per clock through a single full_sub_cell, with a start/done handshake.
module serial_sub_unit
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned    CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;

    logic             w_d;
    logic             w_br_next;

    full_sub_cell u_cell (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_br),
        .d    (w_d),
        .bout (w_br_next)
    );

    // Control FSM, serial datapath and registered result/handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= ain;
                        r_b     <= bin;
                        r_res   <= '0;
                        r_br    <= BORROW_IN;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    r_res <= {w_d, r_res[WIDTH-1:1]};
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_br  <= w_br_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        // Bit 0 of the operand registers now holds the original
                        // MSBs, so the overflow test uses them directly.
                        r_diff  <= {w_d, r_res[WIDTH-1:1]};
                        r_bout  <= w_br_next;
                        r_ovf   <= (r_a[0] != r_b[0]) && (w_d != r_a[0]);
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_sub_unit.sv
// Scoreboard bench for serial_sub_unit at WIDTH=4.
module tb_serial_sub_unit;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } res_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } vec_t;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] ain   = '0;
    logic [W-1:0] bin   = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    res_t q[$];
    int   checks   = 0;
    int   failures = 0;

    serial_sub_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .ain   (ain),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    // Pulses start for one cycle, pushes the expected result, and returns at
    // the falling edge where done is first seen (or after the cycle budget).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input res_t exp, output int lat);
        @(negedge clk);
        ain   = a;
        bin   = b;
        start = 1'b1;
        q.push_back(exp);
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 20);
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({busy, done, diff, bout, ovf} !== '0)
            begin failures++; $display("FAIL reset_outputs got=%b want=0", {busy, done, diff, bout, ovf}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00)
            begin failures++; $display("FAIL reset_idle busy/done got=%b want=00", {busy, done}); end
    endtask

    task automatic test_basic;
        vec_t v[3];
        res_t e;
        int   lat;
        v[0] = '{a:4'h5, b:4'h3, d:4'h2, bo:1'b0, ov:1'b0};
        v[1] = '{a:4'h3, b:4'h5, d:4'hE, bo:1'b1, ov:1'b0};
        v[2] = '{a:4'h8, b:4'h1, d:4'h7, bo:1'b0, ov:1'b1};
        foreach (v[i]) begin
            run_op(v[i].a, v[i].b, '{d:v[i].d, bo:v[i].bo, ov:v[i].ov}, lat);
            e = q.pop_front();
            checks++;
            if (lat !== W)
                begin failures++; $display("FAIL basic%0d_latency got=%0d want=%0d", i, lat, W); end
            checks++;
            if ({diff, bout, ovf} !== {e.d, e.bo, e.ov})
                begin failures++; $display("FAIL basic%0d_result got=%h/%b/%b want=%h/%b/%b", i, diff, bout, ovf, e.d, e.bo, e.ov); end
            checks++;
            if (busy !== 1'b1)
                begin failures++; $display("FAIL basic%0d_busy_in_done got=%b want=1", i, busy); end
            @(negedge clk);
            checks++;
            if ({busy, done} !== 2'b00)
                begin failures++; $display("FAIL basic%0d_after_done busy/done got=%b want=00", i, {busy, done}); end
        end
    endtask

    task automatic test_corners;
        vec_t v[4];
        res_t e;
        int   lat;
        v[0] = '{a:4'h0, b:4'h0, d:4'h0, bo:1'b0, ov:1'b0};
        v[1] = '{a:4'hF, b:4'hF, d:4'h0, bo:1'b0, ov:1'b0};
        v[2] = '{a:4'h0, b:4'hF, d:4'h1, bo:1'b1, ov:1'b0};
        v[3] = '{a:4'h7, b:4'hF, d:4'h8, bo:1'b1, ov:1'b1};
        foreach (v[i]) begin
            run_op(v[i].a, v[i].b, '{d:v[i].d, bo:v[i].bo, ov:v[i].ov}, lat);
            e = q.pop_front();
            checks++;
            if (lat !== W || {diff, bout, ovf} !== {e.d, e.bo, e.ov})
                begin failures++; $display("FAIL corner%0d lat=%0d got=%h/%b/%b want lat=%0d %h/%b/%b", i, lat, diff, bout, ovf, W, e.d, e.bo, e.ov); end
        end
    endtask

    task automatic test_ignore_start;
        res_t e;
        int   lat;
        int   extra;
        @(negedge clk);
        ain   = 4'h6;
        bin   = 4'h1;
        start = 1'b1;
        q.push_back('{d:4'h5, bo:1'b0, ov:1'b0});
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        ain   = 4'hF;
        bin   = 4'hF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1)
            begin failures++; $display("FAIL ignore_busy_in_run got=%b want=1", busy); end
        lat = 3;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        start = 1'b1;
        e = q.pop_front();
        checks++;
        if (lat !== W)
            begin failures++; $display("FAIL ignore_latency got=%0d want=%0d", lat, W); end
        checks++;
        if ({diff, bout, ovf} !== {e.d, e.bo, e.ov})
            begin failures++; $display("FAIL ignore_result got=%h/%b/%b want=%h/%b/%b", diff, bout, ovf, e.d, e.bo, e.ov); end
        checks++;
        if (busy !== 1'b1)
            begin failures++; $display("FAIL ignore_busy_in_done got=%b want=1", busy); end
        @(negedge clk);
        start = 1'b0;
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            if (busy !== 1'b0 || done !== 1'b0) extra++;
            @(negedge clk);
        end
        checks++;
        if (extra !== 0)
            begin failures++; $display("FAIL ignore_no_second_op busy_or_done_cycles got=%0d want=0", extra); end
    endtask

    task automatic test_reset_mid;
        res_t e;
        int   lat;
        int   spurious;
        @(negedge clk);
        ain   = 4'h9;
        bin   = 4'h2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || diff !== 4'h5)
            begin failures++; $display("FAIL rstmid_pre busy/diff got=%b/%h want=1/5", busy, diff); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, diff, bout, ovf} !== '0)
            begin failures++; $display("FAIL rstmid_async_clear got=%b want=0", {busy, done, diff, bout, ovf}); end
        spurious = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) spurious++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) spurious++;
        end
        checks++;
        if (spurious !== 0)
            begin failures++; $display("FAIL rstmid_no_done active_cycles got=%0d want=0", spurious); end
        run_op(4'h6, 4'h2, '{d:4'h4, bo:1'b0, ov:1'b0}, lat);
        e = q.pop_front();
        checks++;
        if (lat !== W || {diff, bout, ovf} !== {e.d, e.bo, e.ov})
            begin failures++; $display("FAIL rstmid_after lat=%0d got=%h/%b/%b want lat=%0d %h/%b/%b", lat, diff, bout, ovf, W, e.d, e.bo, e.ov); end
    endtask

    task automatic test_back_to_back;
        vec_t         v[3];
        res_t         e;
        logic [W-1:0] prev;
        int           n;
        int           unstable;
        int           late;
        v[0] = '{a:4'h9, b:4'h4, d:4'h5, bo:1'b0, ov:1'b1};
        v[1] = '{a:4'h2, b:4'h7, d:4'hB, bo:1'b1, ov:1'b0};
        v[2] = '{a:4'hA, b:4'hA, d:4'h0, bo:1'b0, ov:1'b0};
        prev = 4'h4;
        @(negedge clk);
        ain   = v[0].a;
        bin   = v[0].b;
        start = 1'b1;
        q.push_back('{d:v[0].d, bo:v[0].bo, ov:v[0].ov});
        foreach (v[i]) begin
            n = 0;
            unstable = 0;
            do begin
                @(negedge clk);
                n++;
                if (!done && diff !== prev) unstable++;
            end while (!done && n < 30);
            e = q.pop_front();
            checks++;
            if (n !== ((i == 0) ? W + 1 : W + 2))
                begin failures++; $display("FAIL b2b%0d_period got=%0d want=%0d", i, n, (i == 0) ? W + 1 : W + 2); end
            checks++;
            if ({diff, bout, ovf} !== {e.d, e.bo, e.ov})
                begin failures++; $display("FAIL b2b%0d_result got=%h/%b/%b want=%h/%b/%b", i, diff, bout, ovf, e.d, e.bo, e.ov); end
            checks++;
            if (unstable !== 0)
                begin failures++; $display("FAIL b2b%0d_diff_stable changed_cycles got=%0d want=0", i, unstable); end
            prev = e.d;
            if (i < 2) begin
                ain = v[i+1].a;
                bin = v[i+1].b;
                q.push_back('{d:v[i+1].d, bo:v[i+1].bo, ov:v[i+1].ov});
            end else begin
                start = 1'b0;
            end
        end
        late = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0 || diff !== prev) late++;
        end
        checks++;
        if (late !== 0)
            begin failures++; $display("FAIL b2b_drain extra_activity got=%0d want=0", late); end
        checks++;
        if (q.size() !== 0)
            begin failures++; $display("FAIL scoreboard_empty got=%0d want=0", q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
